// File: rtl/stream_load_dispatch_pkg.sv
// Shared types and widths for the stream load dispatcher.
package stream_load_dispatch_pkg;

    localparam int DATA_WIDTH  = 256;
    localparam int W_CNT_WIDTH = 19;
    localparam int F_CNT_WIDTH = 21;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD_W = 2'd1,
        ST_LOAD_F = 2'd2
    } state_e;

endpackage

// File: rtl/stream_load_dispatch_beat_counter.sv
// Beat counter for one load: latches the target and clears on load,
// increments per accepted beat, flags the beat that finishes the load.
module stream_load_dispatch_beat_counter #(
    parameter int WIDTH = 19
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] target_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o,
    output logic             last_o
);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] target_q, target_d;

    // Next count/target: load has priority over increment.
    always_comb begin
        count_d  = count_q;
        target_d = target_q;
        if (load_i) begin
            count_d  = '0;
            target_d = target_i;
        end else if (inc_i) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Counter and target registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= '0;
            target_q <= '0;
        end else begin
            count_q  <= count_d;
            target_q <= target_d;
        end
    end

    // A zero target never enters a load, so the wrapped compare is never used.
    assign count_o = count_q;
    assign last_o  = (count_q == target_q - WIDTH'(1));

endmodule

// File: rtl/stream_load_dispatch.sv
// Sequences weight/feature loads from the stream source, steering accepted
// beats into the weight or feature buffer write port with one cycle latency.
module stream_load_dispatch
    import stream_load_dispatch_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_para,
    input  logic                   start_feature,
    input  logic [W_CNT_WIDTH-1:0] weight_num,
    input  logic [F_CNT_WIDTH-1:0] feature_num,
    output logic                   DMA_read_para,
    output logic                   DMA_read_feature,
    output logic                   EN,
    input  logic [DATA_WIDTH-1:0]  S_Data,
    input  logic                   S_Valid,
    output logic                   S_Ready,
    input  logic                   feature_almost_full,
    output logic                   weight_wr_en,
    output logic [W_CNT_WIDTH-1:0] weight_wr_addr,
    output logic [DATA_WIDTH-1:0]  weight_wr_data,
    output logic                   feature_wr_en,
    output logic [DATA_WIDTH-1:0]  feature_wr_data,
    output logic                   para_done,
    output logic                   feature_done,
    output logic                   busy
);

    state_e                   state_q, state_d;
    logic                     en_q, en_d;
    logic                     dma_para_q, dma_para_d;
    logic                     dma_feat_q, dma_feat_d;
    logic                     w_wen_q, w_wen_d;
    logic [W_CNT_WIDTH-1:0]   w_addr_q, w_addr_d;
    logic [DATA_WIDTH-1:0]    w_data_q, w_data_d;
    logic                     f_wen_q, f_wen_d;
    logic [DATA_WIDTH-1:0]    f_data_q, f_data_d;
    logic                     p_done_q, p_done_d;
    logic                     f_done_q, f_done_d;

    logic                     accept;
    logic                     w_load, f_load;
    logic [W_CNT_WIDTH-1:0]   w_count;
    logic [F_CNT_WIDTH-1:0]   f_count;
    logic                     w_last, f_last;

    // Para wins a simultaneous start; starts are only honoured in IDLE.
    assign w_load = (state_q == ST_IDLE) && start_para;
    assign f_load = (state_q == ST_IDLE) && !start_para && start_feature;
    assign accept = S_Valid && S_Ready;

    stream_load_dispatch_beat_counter #(.WIDTH(W_CNT_WIDTH)) u_w_cnt (
        .clk      (clk),
        .rst      (rst),
        .load_i   (w_load),
        .target_i (weight_num),
        .inc_i    (accept && (state_q == ST_LOAD_W)),
        .count_o  (w_count),
        .last_o   (w_last)
    );

    stream_load_dispatch_beat_counter #(.WIDTH(F_CNT_WIDTH)) u_f_cnt (
        .clk      (clk),
        .rst      (rst),
        .load_i   (f_load),
        .target_i (feature_num),
        .inc_i    (accept && (state_q == ST_LOAD_F)),
        .count_o  (f_count),
        .last_o   (f_last)
    );

    // Ready depends on state only (plus feature backpressure).
    always_comb begin
        S_Ready = 1'b0;
        case (state_q)
            ST_LOAD_W: S_Ready = 1'b1;
            ST_LOAD_F: S_Ready = !feature_almost_full;
            default:   S_Ready = 1'b0;
        endcase
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_d    = state_q;
        en_d       = en_q;
        dma_para_d = 1'b0;
        dma_feat_d = 1'b0;
        w_wen_d    = 1'b0;
        w_addr_d   = w_addr_q;
        w_data_d   = w_data_q;
        f_wen_d    = 1'b0;
        f_data_d   = f_data_q;
        p_done_d   = 1'b0;
        f_done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_load) begin
                    en_d = 1'b1;
                    if (weight_num == '0) begin
                        p_done_d = 1'b1;
                    end else begin
                        state_d    = ST_LOAD_W;
                        dma_para_d = 1'b1;
                    end
                end else if (f_load) begin
                    en_d = 1'b0;
                    if (feature_num == '0) begin
                        f_done_d = 1'b1;
                    end else begin
                        state_d    = ST_LOAD_F;
                        dma_feat_d = 1'b1;
                    end
                end
            end
            ST_LOAD_W: begin
                if (accept) begin
                    w_wen_d  = 1'b1;
                    w_addr_d = w_count;
                    w_data_d = S_Data;
                    if (w_last) begin
                        state_d  = ST_IDLE;
                        p_done_d = 1'b1;
                    end
                end
            end
            ST_LOAD_F: begin
                if (accept) begin
                    f_wen_d  = 1'b1;
                    f_data_d = S_Data;
                    if (f_last) begin
                        state_d  = ST_IDLE;
                        f_done_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset drops any pending write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            en_q       <= 1'b0;
            dma_para_q <= 1'b0;
            dma_feat_q <= 1'b0;
            w_wen_q    <= 1'b0;
            w_addr_q   <= '0;
            w_data_q   <= '0;
            f_wen_q    <= 1'b0;
            f_data_q   <= '0;
            p_done_q   <= 1'b0;
            f_done_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            en_q       <= en_d;
            dma_para_q <= dma_para_d;
            dma_feat_q <= dma_feat_d;
            w_wen_q    <= w_wen_d;
            w_addr_q   <= w_addr_d;
            w_data_q   <= w_data_d;
            f_wen_q    <= f_wen_d;
            f_data_q   <= f_data_d;
            p_done_q   <= p_done_d;
            f_done_q   <= f_done_d;
        end
    end

    assign DMA_read_para    = dma_para_q;
    assign DMA_read_feature = dma_feat_q;
    assign EN               = en_q;
    assign weight_wr_en     = w_wen_q;
    assign weight_wr_addr   = w_addr_q;
    assign weight_wr_data   = w_data_q;
    assign feature_wr_en    = f_wen_q;
    assign feature_wr_data  = f_data_q;
    assign para_done        = p_done_q;
    assign feature_done     = f_done_q;
    assign busy             = (state_q != ST_IDLE);

    // The feature buffer has no address port; its count only drives the terminal flag.
    logic f_count_unused;
    assign f_count_unused = ^f_count;

endmodule
